// File: rtl/plot_request_sink_if.sv
// plot_request_sink_if: request bus carrying N lanes of (x, y, colour) pixel-plot requests.
// Lane i uses bits [8i+7:8i] of req_x, [7i+6:7i] of req_y and [3i+2:3i] of req_colour.
// Handshake: lane i transfers one pixel on a posedge where req_valid[i] && req_ready[i].
// A lane holds valid and data stable until ready; it may drop valid without a transfer.
// req_ready is one-hot or all zero.
interface plot_request_sink_if #(
  parameter int N_LANES = 4
);
  logic [N_LANES-1:0]   req_valid;
  logic [8*N_LANES-1:0] req_x;
  logic [7*N_LANES-1:0] req_y;
  logic [3*N_LANES-1:0] req_colour;
  logic [N_LANES-1:0]   req_ready;

  modport master (
    output req_valid, req_x, req_y, req_colour,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_x, req_y, req_colour,
    output req_ready
  );
endinterface

// File: rtl/plot_request_sink.sv
// plot_request_sink: round-robin arbiter over N plot lanes feeding a FIFO that drains one
// pixel per cycle onto the vga_adapter x/y/colour/plot port.
// Optional feature macro: PLOT_CLIP_EN -- off-screen requests (x >= X_MAX or y >= Y_MAX)
// are still handshaken but discarded and counted in drop_count (saturating). Without the
// macro every request is stored and drop_count stays 0.
module plot_request_sink #(
  parameter int N_LANES = 4,
  parameter int DEPTH   = 16,
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120
) (
  input  logic                   clk,
  input  logic                   resetn,
  plot_request_sink_if.slave     req,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [8:0]  X_LIM    = X_MAX[8:0];
  localparam logic [7:0]  Y_LIM    = Y_MAX[7:0];
`ifdef PLOT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic [17:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      rr_ptr;
  logic [N_LANES-1:0] grant;
  logic               grant_any;
  logic [LW-1:0]      gidx;
  logic [LW-1:0]      scan;
  logic [7:0]         sel_x;
  logic [6:0]         sel_y;
  logic [2:0]         sel_colour;
  logic               full;
  logic               oob;
  logic               clip;
  logic               push;
  logic               pop;
  logic               drain_en;

  // Drain enable: tied high; the pop path is gated by it so the drain can be paused.
  assign drain_en = 1'b1;

  // Full is judged on the registered count only; a same-cycle pop does not free a slot.
  assign full = (fifo_count == FULL_CNT);

  // Round-robin scan starting at rr_ptr; the first valid lane wins and its data is selected.
  always_comb begin
    grant      = '0;
    grant_any  = 1'b0;
    gidx       = '0;
    scan       = '0;
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int i = 0; i < N_LANES; i++) begin
      scan = LW'((int'(rr_ptr) + i) % N_LANES);
      if (!grant_any && !full && resetn && req.req_valid[scan]) begin
        grant_any   = 1'b1;
        grant[scan] = 1'b1;
        gidx        = scan;
      end
    end
    for (int i = 0; i < N_LANES; i++) begin
      if (grant[i]) begin
        sel_x      = req.req_x[8*i +: 8];
        sel_y      = req.req_y[7*i +: 7];
        sel_colour = req.req_colour[3*i +: 3];
      end
    end
  end

  assign req.req_ready = grant;

  assign oob  = ({1'b0, sel_x} >= X_LIM) || ({1'b0, sel_y} >= Y_LIM);
  assign clip = CLIP_EN && grant_any && oob;
  assign push = grant_any && !clip;
  assign pop  = (fifo_count != '0) && drain_en;

  // Round-robin pointer moves past the granted lane on every transfer (clipped ones too).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (gidx == LW'(N_LANES - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sel_x, sel_y, sel_colour};
  end

  // Drain stage: one pixel per cycle while entries exist; x/y/colour hold when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else if (pop) begin
      {x, y, colour} <= mem[rd_ptr];
      plot           <= 1'b1;
    end else begin
      plot <= 1'b0;
    end
  end

  // Clipped-request counter, saturating; constant 0 when clipping is compiled out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (clip && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
endmodule
